rr_decoder_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters.
//  - Picks one requester per grant and drives the decoder's 3-bit select and

---
 rtl/rr_decoder_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin arbiter that shares one 3-to-8 decoder among
// eight requesters. It drives the decoder select/enable and a matching one-hot
// grant vector. Every grant is followed by one GAP cycle with the enable low,
// which gives the decoder break-before-make.
//
// Optional feature: define ARB_LOCK_EN to add the `lock` input. While lock is
// high, the holder is not preempted by HOLD_MAX.
//
// Handshake: req[i] is a level request, and it is never latched. A requester is
// served when its bit is high during the IDLE scan. It keeps the decoder for as
// long as its bit stays high, until HOLD_MAX expires (unless it is locked).
// It gives up the grant by dropping its bit.
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] grant,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Hold counter width is clog2(HOLD_MAX+1), with a minimum of one bit.
    localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    // The counter stops at HOLD_MAX. With HOLD_MAX = 0 it stops at all-ones instead.
    localparam logic [HW-1:0] HCNT_SAT = (HOLD_MAX == 0) ? {HW{1'b1}} : HW'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    last;
    logic [HW-1:0] hcnt;

    logic          lock_act;
    logic          expired;
    logic          win_found;
    logic [2:0]    win_idx;
    logic [2:0]    cand;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign dbg_state = state;

    // A grant expires once HOLD_MAX is reached, unless the holder has it locked.
    assign expired = (HOLD_MAX != 0) && (hcnt == HCNT_SAT) && !lock_act;

    // Round-robin scan: look at last+1 first and wrap modulo 8, so the last holder comes last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbitration FSM. All outputs are registered here, and reset overrides every other condition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            en    <= 1'b0;
            grant <= 8'd0;
            busy  <= 1'b0;
            last  <= 3'd7;
            hcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= GRANT;
                        sel   <= win_idx;
                        en    <= 1'b1;
                        grant <= 8'd1 << win_idx;
                        busy  <= 1'b1;
                        hcnt  <= HW'(1);
                    end else begin
                        en    <= 1'b0;
                        grant <= 8'd0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[sel] || expired) begin
                        state <= GAP;
                        en    <= 1'b0;
                        grant <= 8'd0;
                        last  <= sel;
                    end else if (hcnt != HCNT_SAT) begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    grant <= 8'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter: directed scenarios and randomized traffic for
// rr_decoder_arbiter. An independent behavioural model checks the outputs on
// every cycle. The directed scenarios also check literal expected values.
module tb_rr_decoder_arbiter;

  localparam int HM = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       lock_drv;
  logic [2:0] sel;
  logic       en;
  logic [7:0] grant;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rr_decoder_arbiter #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock_drv),
`endif
    .sel       (sel),
    .en        (en),
    .grant     (grant),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: who holds the decoder, for how long, and who was served last
  int m_holder = -1;
  int m_held   = 0;
  bit m_gap    = 1'b0;
  int m_last   = 7;
  int m_sel    = 0;
  logic [12:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_holder = -1; m_held = 0; m_gap = 1'b0; m_last = 7; m_sel = 0;
    end else if (m_holder >= 0) begin
      if (!req[m_holder] || (HM != 0 && m_held >= HM && !lock_drv)) begin
        m_last = m_holder; m_holder = -1; m_gap = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 8'd0) begin
      for (int k = 1; k <= 8; k++) begin
        if (m_holder < 0 && req[(m_last + k) % 8]) m_holder = (m_last + k) % 8;
      end
      m_sel = m_holder;
      m_held = 1;
    end
    begin
      logic       e_en, e_busy;
      logic [7:0] e_grant;
      e_en    = (m_holder >= 0);
      e_busy  = (m_holder >= 0) || m_gap;
      e_grant = e_en ? (8'd1 << m_sel) : 8'd0;
      exp_q.push_back({e_busy, e_en, 3'(m_sel), e_grant});
    end
  end

  // compare process: runs 1 ns after every active edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 32'd0, 32'd1);
    end else begin
      check("cycle_outputs", {19'd0, busy, en, sel, grant}, {19'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_en(input string name, output int gaps);
    gaps = 0;
    while (en !== 1'b1 && gaps < 50) begin
      gaps++;
      tick();
    end
    check(name, en, 1'b1);
  endtask

  task automatic run_len(output int len);
    len = 0;
    while (en === 1'b1 && len < 40) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int gaps;
    int len;
    logic [2:0] w;
    rst_n = 1'b0; req = 8'hFF; lock_drv = 1'b0;

    // reset held for 3 edges while every requester is asking
    repeat (3) begin
      tick();
      check("reset_sel", sel, 3'd0);
      check("reset_en", en, 1'b0);
      check("reset_grant", grant, 8'd0);
      check("reset_busy", busy, 1'b0);
    end
    rst_n = 1'b1; req = 8'h00;
    repeat (2) tick();

    // round-robin wrap: 0,7,0,7... each grant released after 2 cycles
    req = 8'h81;
    for (int g = 0; g < 6; g++) begin
      wait_en("rr_grant_seen", gaps);
      check("rr_winner", sel, (g % 2 == 1) ? 3'd7 : 3'd0);
      if (g > 0) check("rr_gap_cycles", gaps, 2);
      w = sel;
      tick();
      check("rr_second_cycle_en", en, 1'b1);
      req = 8'h81 & ~(8'd1 << w);
      tick();
      check("rr_release_gap", {busy, en}, 2'b10);
      req = 8'h81;
    end
    req = 8'h00;
    repeat (3) tick();

    // single request with 1-cycle latency, then release
    req = 8'h10;
    tick();
    check("single_sel", sel, 3'd4);
    check("single_en", en, 1'b1);
    check("single_grant", grant, 8'h10);
    req = 8'h00;
    tick();
    check("single_gap", {busy, en, grant}, {2'b10, 8'd0});
    tick();
    check("single_idle", {busy, en, grant}, 10'd0);

    // preemption after HM cycles: grant 1, then 2, then 1 again
    req = 8'h06;
    wait_en("pre_first", gaps);
    check("pre_first_sel", sel, 3'd1);
    run_len(len);
    check("pre_first_len", len, HM);
    wait_en("pre_second", gaps);
    check("pre_second_gap", gaps, 2);
    check("pre_second_sel", sel, 3'd2);
    run_len(len);
    check("pre_second_len", len, HM);
    wait_en("pre_third", gaps);
    check("pre_third_sel", sel, 3'd1);
    req = 8'h00;
    repeat (4) tick();

    // reset during a grant restores top priority for requester 0
    req = 8'h20;
    wait_en("mid_grant", gaps);
    check("mid_sel", sel, 3'd5);
    rst_n = 1'b0;
    tick();
    check("mid_reset_outputs", {busy, en, grant}, 10'd0);
    rst_n = 1'b1; req = 8'h21;
    wait_en("mid_after", gaps);
    check("mid_after_sel", sel, 3'd0);
    req = 8'h00;
    repeat (4) tick();

`ifdef ARB_LOCK_EN
    // lock keeps the grant past HM. Dropping lock expires it on the next edge
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 8'h03; lock_drv = 1'b1;
    wait_en("lock_grant", gaps);
    check("lock_sel", sel, 3'd0);
    repeat (12) begin
      tick();
      check("lock_held", {en, sel}, {1'b1, 3'd0});
    end
    lock_drv = 1'b0;
    tick();
    check("lock_release_gap", {busy, en}, 2'b10);
    wait_en("lock_next", gaps);
    check("lock_next_sel", sel, 3'd1);
    req = 8'h00;
    repeat (4) tick();
`endif

    // randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      rst_n = ($urandom_range(0, 199) != 0);
`ifdef ARB_LOCK_EN
      lock_drv = ($urandom_range(0, 2) == 0);
`endif
    end
    rst_n = 1'b1; req = 8'h00; lock_drv = 1'b0;
    repeat (4) tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
